// File: rtl/inciso2_sweep_ctrl.sv
// inciso2_sweep_ctrl
//   Walks the five-input inciso-2 function through all 32 input vectors,
//   samples S_OR for each one and builds the full truth table plus a count
//   of its set bits (the minterm count).
//
// Parameters
//   SETTLE    extra wait cycles between applying a vector and sampling (0..15)
//   EXPECTED  golden truth table (present only with SWEEP_CHECK_EN)
//
// Optional feature macro: SWEEP_CHECK_EN
//   When defined, the final table is compared against EXPECTED as the sweep
//   completes, and the result is held on mismatch. When undefined, mismatch
//   is tied low and no comparator exists.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     sweep request, sampled in IDLE only
//   abort     cancel a running sweep (wins over start in IDLE)
//   f_in      S_OR returned by the function instance
//   x_o..m_o  function inputs; vector index = {X,Y,Z,K,M}, X is the MSB
//   busy      high while sweeping
//   done      one-cycle pulse when a sweep completes
//   table_o   bit i holds f(i)
//   ones_o    number of set bits in table_o (0..32)
//   mismatch  final table differs from EXPECTED
module inciso2_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
`ifdef SWEEP_CHECK_EN
  , parameter logic [31:0] EXPECTED = 32'h0A3E8C5C
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic        x_o,
  output logic        y_o,
  output logic        z_o,
  output logic        k_o,
  output logic        m_o,
  output logic        busy,
  output logic        done,
  output logic [31:0] table_o,
  output logic [5:0]  ones_o,
  output logic        mismatch
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t     state;
  logic [4:0] idx;
  logic [3:0] cnt;

  // idx is returned to zero whenever the sweep leaves WAIT, so it can drive
  // the function inputs directly and still read zero in IDLE and DONE.
  assign {x_o, y_o, z_o, k_o, m_o} = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      table_o <= '0;
      ones_o  <= '0;
`ifdef SWEEP_CHECK_EN
      mismatch <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            table_o <= '0;
            ones_o  <= '0;
            idx     <= '0;
            cnt     <= SETTLE_CNT;
            busy    <= 1'b1;
            state   <= WAIT;
`ifdef SWEEP_CHECK_EN
            mismatch <= 1'b0;
`endif
          end
        end

        WAIT: begin
          if (abort) begin
            // Partial results are kept; the sample due this cycle is dropped.
            busy  <= 1'b0;
            idx   <= '0;
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            table_o[idx] <= f_in;
            ones_o       <= ones_o + {5'd0, f_in};
            if (idx == 5'd31) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              idx   <= '0;
              state <= DONE;
`ifdef SWEEP_CHECK_EN
              // Bit 31 is being written this same edge, so splice it in.
              mismatch <= ({f_in, table_o[30:0]} != EXPECTED);
`endif
            end else begin
              idx <= idx + 5'd1;
              cnt <= SETTLE_CNT;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SWEEP_CHECK_EN
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_inciso2_sweep_ctrl.sv
module tb_inciso2_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A: SETTLE=1 driven by the real function.
  // Instance B: SETTLE=0 driven by a constant-1 function.
  logic        start_a = 1'b0, abort_a = 1'b0;
  logic        start_b = 1'b0, abort_b = 1'b0;
  logic        f_a, f_b;
  logic        xa, ya, za, ka, ma, busy_a, done_a, mis_a;
  logic        xb, yb, zb, kb, mb, busy_b, done_b, mis_b;
  logic [31:0] tab_a, tab_b;
  logic [5:0]  ones_a, ones_b;
  logic [4:0]  vec_a, vec_b;
  logic [31:0] gold = 32'h0A3E8C5C;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  assign vec_a = {xa, ya, za, ka, ma};
  assign vec_b = {xb, yb, zb, kb, mb};
  assign f_a   = gold[vec_a];
  assign f_b   = 1'b1;

  always #5 clk = ~clk;

  inciso2_sweep_ctrl #(.SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .f_in(f_a),
    .x_o(xa), .y_o(ya), .z_o(za), .k_o(ka), .m_o(ma),
    .busy(busy_a), .done(done_a), .table_o(tab_a), .ones_o(ones_a),
    .mismatch(mis_a)
  );

  inciso2_sweep_ctrl #(.SETTLE(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .f_in(f_b),
    .x_o(xb), .y_o(yb), .z_o(zb), .k_o(kb), .m_o(mb),
    .busy(busy_b), .done(done_b), .table_o(tab_b), .ones_o(ones_b),
    .mismatch(mis_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time-based view of a sweep: m_t counts WAIT cycles since acceptance;
  // the vector shown is m_t / hold and a sample lands on the last cycle of
  // each hold window. Sweep ends after 32*hold WAIT cycles.
  logic        m_busy [2];
  logic        m_done [2];
  logic        m_mis  [2];
  logic [31:0] m_tab  [2];
  logic [5:0]  m_ones [2];
  int unsigned m_t    [2];

  function automatic int unsigned hold_of(input int n);
    return (n == 0) ? 2 : 1;
  endfunction

  function automatic logic st_of(input int n);
    return (n == 0) ? start_a : start_b;
  endfunction

  function automatic logic ab_of(input int n);
    return (n == 0) ? abort_a : abort_b;
  endfunction

  function automatic logic [4:0] exp_vec(input int n);
    return m_busy[n] ? 5'(m_t[n] / hold_of(n)) : 5'd0;
  endfunction

  function automatic logic mf(input int n);
    return (n == 1) ? 1'b1 : gold[exp_vec(n)];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        m_busy[n] <= 1'b0;
        m_done[n] <= 1'b0;
        m_mis[n]  <= 1'b0;
        m_tab[n]  <= '0;
        m_ones[n] <= '0;
        m_t[n]    <= 0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (m_done[n]) begin
          m_done[n] <= 1'b0;
        end else if (!m_busy[n]) begin
          if (st_of(n) && !ab_of(n)) begin
            m_busy[n] <= 1'b1;
            m_t[n]    <= 0;
            m_tab[n]  <= '0;
            m_ones[n] <= '0;
            m_mis[n]  <= 1'b0;
          end
        end else if (ab_of(n)) begin
          m_busy[n] <= 1'b0;
        end else begin
          m_t[n] <= m_t[n] + 1;
          if ((m_t[n] + 1) % hold_of(n) == 0) begin
            m_tab[n][exp_vec(n)] <= mf(n);
            m_ones[n] <= m_ones[n] + 6'(mf(n));
          end
          if (m_t[n] + 1 == 32 * hold_of(n)) begin
            m_busy[n] <= 1'b0;
            m_done[n] <= 1'b1;
`ifdef SWEEP_CHECK_EN
            m_mis[n] <= ({mf(n), m_tab[n][30:0]} != gold);
`endif
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("busy_a", busy_a, m_busy[0]);
      check("done_a", done_a, m_done[0]);
      check("vec_a",  vec_a,  exp_vec(0));
      check("tab_a",  tab_a,  m_tab[0]);
      check("ones_a", ones_a, m_ones[0]);
      check("mis_a",  mis_a,  m_mis[0]);
      check("busy_b", busy_b, m_busy[1]);
      check("done_b", done_b, m_done[1]);
      check("vec_b",  vec_b,  exp_vec(1));
      check("tab_b",  tab_b,  m_tab[1]);
      check("ones_b", ones_b, m_ones[1]);
      check("mis_b",  mis_b,  m_mis[1]);
    end
  end

  // Pulse start for one cycle and count cycles after acceptance until done.
  // k=1 is the first cycle after the accepting edge; 200 is the bound.
  task automatic sweep(input int which, output int k);
    @(negedge clk);
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    k = 1;
    while (!((which == 0) ? done_a : done_b) && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int k;
    int nd;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy",  busy_a, 32'd0);
    check("rst_done",  done_a, 32'd0);
    check("rst_vec",   vec_a,  32'd0);
    check("rst_table", tab_a,  32'd0);
    check("rst_ones",  ones_a, 32'd0);
    check("rst_mis",   mis_a,  32'd0);
    rst = 1'b0;

    // Real function, SETTLE=1
    sweep(0, k);
    check("a_done_cycle", k,      32'd65);
    check("a_table",      tab_a,  32'h0A3E8C5C);
    check("a_ones",       ones_a, 32'd14);
    check("a_mismatch",   mis_a,  32'd0);

    // Constant-1 function, SETTLE=0
    sweep(1, k);
    check("b_done_cycle", k,      32'd33);
    check("b_table",      tab_b,  32'hFFFFFFFF);
    check("b_ones",       ones_b, 32'd32);
`ifdef SWEEP_CHECK_EN
    check("b_mismatch",   mis_b,  32'd1);
`else
    check("b_mismatch",   mis_b,  32'd0);
`endif

    // Abort right after vector 10 has been captured (first cycle of idx 11)
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 0;
    while (vec_a != 5'd11 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("abort_reach_idx", vec_a, 32'd11);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("abort_busy",  busy_a, 32'd0);
    check("abort_done",  done_a, 32'd0);
    check("abort_table", tab_a,  32'h0000045C);
    check("abort_ones",  ones_a, 32'd5);
    nd = 0;
    repeat (70) begin
      @(negedge clk);
      nd += int'(done_a);
    end
    check("abort_no_done", nd, 32'd0);

    // start held high through a sweep
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    k = 1;
    while (!done_a && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("held_done_cycle", k, 32'd65);
    @(negedge clk);
    check("held_idle_busy",  busy_a, 32'd0);
    check("held_idle_table", tab_a,  32'h0A3E8C5C);
    @(negedge clk);
    check("held_restart_busy",  busy_a, 32'd1);
    check("held_restart_table", tab_a,  32'd0);
    check("held_restart_ones",  ones_a, 32'd0);
    start_a = 1'b0;
    k = 1;
    while (!done_a && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("held_second_done", k, 32'd65);

    // start and abort together in IDLE
    @(negedge clk);
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    check("sa_busy",  busy_a, 32'd0);
    check("sa_table", tab_a,  32'h0A3E8C5C);
    repeat (3) @(negedge clk);
    check("sa_busy_later", busy_a, 32'd0);

    // Asynchronous reset mid-sweep at idx 20
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 0;
    while (vec_a != 5'd20 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rst_reach_idx", vec_a, 32'd20);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",  busy_a, 32'd0);
    check("arst_done",  done_a, 32'd0);
    check("arst_vec",   vec_a,  32'd0);
    check("arst_table", tab_a,  32'd0);
    check("arst_ones",  ones_a, 32'd0);
    check("arst_mis",   mis_a,  32'd0);
    @(negedge clk);
    rst = 1'b0;
    sweep(0, k);
    check("post_rst_done_cycle", k,      32'd65);
    check("post_rst_table",      tab_a,  32'h0A3E8C5C);
    check("post_rst_ones",       ones_a, 32'd14);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
